// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, req/ready fetch handshake, one-entry skid buffer,
// branch redirect (immediate or deferred until the outstanding fetch completes) and IF/ID.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  opcode
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign target_s   = {branch_target[31:2], 2'b00};

  assign imem_req   = (state_q == S_FETCH) & rst_n;
  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign opcode     = ifid_instr_q[31:26];

  // Next-state logic; a pending redirect is only applied once the outstanding fetch is accepted.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;

    case (state_q)
      S_FETCH: begin
        if (branch_taken) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'h0000_0000;
          ifid_pc4_d   = 32'h0000_0000;
          if (imem_ready) begin
            pc_d         = target_s;
            redir_pend_d = 1'b0;
          end else begin
            redir_pend_d = 1'b1;
            redir_addr_d = target_s;
          end
        end else if (imem_ready) begin
          if (redir_pend_q) begin
            pc_d         = redir_addr_q;
            redir_pend_d = 1'b0;
            if (!stall) begin
              ifid_valid_d = 1'b0;
              ifid_instr_d = 32'h0000_0000;
              ifid_pc4_d   = 32'h0000_0000;
            end else begin
              ifid_valid_d = ifid_valid_q;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4_s;
            pc_d         = pc_plus4_s;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4_s;
            pc_d        = pc_plus4_s;
            state_d     = S_FULL;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'h0000_0000;
          ifid_pc4_d   = 32'h0000_0000;
        end else begin
          ifid_valid_d = ifid_valid_q;
        end
      end
      S_FULL: begin
        if (branch_taken) begin
          buf_instr_d  = 32'h0000_0000;
          buf_pc4_d    = 32'h0000_0000;
          pc_d         = target_s;
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'h0000_0000;
          ifid_pc4_d   = 32'h0000_0000;
          state_d      = S_FETCH;
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = buf_instr_q;
          ifid_pc4_d   = buf_pc4_q;
          state_d      = S_FETCH;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_addr_q <= 32'h0000_0000;
      buf_instr_q  <= 32'h0000_0000;
      buf_pc4_q    <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized traffic,
// all checked against a transaction-level reference model (queues for skid and redirect).
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;

  int n_total;
  int n_bad;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .opcode       (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t       m_ifid;
  logic [31:0] m_pc;
  logic [63:0] m_skid[$];
  logic [31:0] m_redir[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0000_0000;
    m_ifid = '0;
    m_skid.delete();
    m_redir.delete();
  endtask

  task automatic model_step(input logic rdy, input logic st, input logic br,
                            input logic [31:0] tgt, input logic [31:0] rd);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (m_skid.size() != 0) begin
      if (br) begin
        m_skid.delete();
        m_pc   = t;
        m_ifid = '0;
      end else if (!st) begin
        m_ifid = {1'b1, m_skid[0][63:32], m_skid[0][31:0]};
        m_skid.delete();
      end
    end else if (br) begin
      m_ifid = '0;
      m_redir.delete();
      if (rdy) m_pc = t;
      else m_redir.push_back(t);
    end else if (rdy) begin
      if (m_redir.size() != 0) begin
        m_pc = m_redir.pop_front();
        if (!st) m_ifid = '0;
      end else begin
        if (st) m_skid.push_back({rd, m_pc + 32'd4});
        else m_ifid = {1'b1, rd, m_pc + 32'd4};
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_ifid = '0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".req"},   {31'd0, imem_req},   {31'd0, (m_skid.size() == 0) & rst_n});
    check({tag, ".addr"},  imem_addr,           m_pc);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_ifid.v});
    check({tag, ".instr"}, ifid_instr,          m_ifid.instr);
    check({tag, ".pc4"},   ifid_pc4,            m_ifid.pc4);
    check({tag, ".opc"},   {26'd0, opcode},     {26'd0, m_ifid.instr[31:26]});
  endtask

  task automatic step(input string tag, input logic rdy, input logic st, input logic br,
                      input logic [31:0] tgt, input logic [31:0] rd);
    imem_ready    = rdy;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = rd;
    @(posedge clk);
    model_step(rdy, st, br, tgt, rd);
    #1;
    compare_all(tag);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    imem_ready = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    imem_rdata = 32'h0;
    model_reset();

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst.req",   {31'd0, imem_req},   32'd0);
    check("rst.valid", {31'd0, ifid_valid}, 32'd0);
    check("rst.opc",   {26'd0, opcode},     32'd0);
    check("rst.addr",  imem_addr,           32'h0);
    rst_n = 1'b1;
    #1;
    compare_all("rel");

    // Back-to-back fetches
    step("seq0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h8C00_0000);
    check("seq0.opc_lw", {26'd0, opcode}, 32'h23);
    check("seq0.addr4",  imem_addr, 32'h4);
    step("seq1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0020);
    check("seq1.pc4", ifid_pc4, 32'h8);
    step("seq2", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    check("seq2.pc4", ifid_pc4, 32'hC);
    step("seq3", 1'b1, 1'b0, 1'b0, 32'h0, 32'hAC00_0000);

    // Wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      step("wait", 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      check("wait.addr10", imem_addr, 32'h10);
    end
    step("wait.acc", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0123_4567);
    check("wait.pc4_14", ifid_pc4, 32'h14);

    // Skid on stall, then release
    step("skid.in", 1'b1, 1'b1, 1'b0, 32'h0, 32'h2001_0005);
    check("skid.req0",  {31'd0, imem_req}, 32'd0);
    check("skid.hold",  ifid_instr, 32'h0123_4567);
    step("skid.hold2", 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
    step("skid.out", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("skid.instr", ifid_instr, 32'h2001_0005);
    check("skid.opc",   {26'd0, opcode}, 32'h08);
    check("skid.req1",  {31'd0, imem_req}, 32'd1);
    check("skid.addr",  imem_addr, 32'h18);

    // Branch while a fetch at 0x20 is outstanding
    step("adv0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1111_1111);
    step("adv1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
    check("br.at20", imem_addr, 32'h20);
    step("br.pend", 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    check("br.hold20", imem_addr, 32'h20);
    check("br.flush",  {31'd0, ifid_valid}, 32'd0);
    step("br.drop", 1'b1, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
    check("br.addr100", imem_addr, 32'h100);
    check("br.nop",     ifid_instr, 32'h0);
    step("br.tgt", 1'b1, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
    check("br.tgt_pc4", ifid_pc4, 32'h104);

    // Branch while holding a skid entry
    step("full.in", 1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
    step("full.br", 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
    check("full.valid0", {31'd0, ifid_valid}, 32'd0);
    check("full.addr40", imem_addr, 32'h40);
    check("full.req1",   {31'd0, imem_req}, 32'd1);

    // PC wrap, target low bits forced to zero
    step("wrap.br", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    step("wrap.acc", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0C00_0001);
    check("wrap.pc4",  ifid_pc4, 32'h0);
    check("wrap.addr0", imem_addr, 32'h0);

    // Reset in the middle of a request
    step("mid.a", 1'b1, 1'b0, 1'b0, 32'h0, 32'h6666_6666);
    step("mid.b", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid.addr",  imem_addr, 32'h0);
    check("mid.req",   {31'd0, imem_req}, 32'd0);
    check("mid.valid", {31'd0, ifid_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compare_all("mid.rel");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom();
      step("rnd", r, s, b, t, mem_word(m_pc));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
